// File: rtl/traffic_pkg.sv
// traffic_pkg: shared state encoding and density threshold for smart_intersection
package traffic_pkg;
  typedef enum logic [2:0] {ALL_RED, GREEN, YELLOW, PED_WALK, EMERG} state_e;
  localparam logic [1:0] DENS_HI = 2'b10;
endpackage

// File: rtl/phase_timer.sv
// phase_timer: phase counter with clear and terminal compare
//   clk, reset_n : clock, async active-low reset
//   clr          : restart the count at zero (state entry)
//   tc           : terminal count (phase length - 1)
//   done         : count has reached tc; the count saturates so done holds while a phase is extended
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic [CNT_W-1:0] tc,
  output logic             done
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : (&cnt_q ? cnt_q : cnt_q + 1'b1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign done = cnt_q >= tc;
endmodule

// File: rtl/smart_intersection.sv
// smart_intersection: round-robin traffic light controller with pedestrian and emergency handling
//   clk, reset_n        : clock, async active-low reset
//   ped_req             : pedestrian request pulses, latched until served
//   emerg_req           : emergency request levels, lowest index wins
//   density             : 2-bit density per approach, sampled at green entry
//   light_red/yellow/green, ped_walk : per-approach lamp and walk drives
//   active_idx          : approach being served
//   emerg_active        : high while in emergency pre-emption
module smart_intersection
  import traffic_pkg::*;
#(
  parameter int N_APPROACH  = 4,
  parameter int CNT_W       = 8,
  parameter int T_CLR       = 2,
  parameter int T_GREEN_MIN = 8,
  parameter int T_GREEN_MAX = 15,
  parameter int T_YELLOW    = 3,
  parameter int T_PED       = 6,
  parameter int T_EMERG     = 10
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [N_APPROACH-1:0]         ped_req,
  input  logic [N_APPROACH-1:0]         emerg_req,
  input  logic [2*N_APPROACH-1:0]       density,
  output logic [N_APPROACH-1:0]         light_red,
  output logic [N_APPROACH-1:0]         light_yellow,
  output logic [N_APPROACH-1:0]         light_green,
  output logic [N_APPROACH-1:0]         ped_walk,
  output logic [$clog2(N_APPROACH)-1:0] active_idx,
  output logic                          emerg_active
);
  localparam int IW = $clog2(N_APPROACH);
  state_e                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d, ek, nxt_idx;
  logic [N_APPROACH-1:0] ped_q, ped_d, walk_q, walk_d, onehot;
  logic                  long_q, long_d, any_e, done, ped_entry, green_entry;
  logic [CNT_W-1:0]      tc;
  logic [1:0]            dens [N_APPROACH];
  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (state_d != state_q),
    .tc      (tc),
    .done    (done)
  );
  always_comb begin
    ek = '0;
    for (int k = N_APPROACH - 1; k >= 0; k--) if (emerg_req[k]) ek = IW'(k);
    for (int k = 0; k < N_APPROACH; k++) dens[k] = density[2*k +: 2];
  end
  assign any_e   = |emerg_req;
  assign nxt_idx = (idx_q == IW'(N_APPROACH - 1)) ? '0 : idx_q + 1'b1;
  // A pending walk request cuts a long green back to the minimum.
  assign tc = state_q == GREEN    ? ((|ped_q || !long_q) ? CNT_W'(T_GREEN_MIN - 1) : CNT_W'(T_GREEN_MAX - 1)) :
              state_q == YELLOW   ? CNT_W'(T_YELLOW - 1) :
              state_q == PED_WALK ? CNT_W'(T_PED - 1) :
              state_q == EMERG    ? CNT_W'(T_EMERG - 1) : CNT_W'(T_CLR - 1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= ALL_RED;
      idx_q   <= '0;
      ped_q   <= '0;
      walk_q  <= '0;
      long_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ped_q   <= ped_d;
      walk_q  <= walk_d;
      long_q  <= long_d;
    end
  // The index advances on entry to ALL_RED, so the all-red exit serves idx_q directly.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ALL_RED: if (done) begin
        state_d = any_e ? EMERG : GREEN;
        idx_d   = any_e ? ek : idx_q;
      end
      GREEN:
        if (any_e && ek == idx_q) state_d = EMERG;
        else if (any_e || done) state_d = YELLOW;
      YELLOW: if (done) begin
        state_d = (|ped_q && !any_e) ? PED_WALK : ALL_RED;
        idx_d   = (|ped_q && !any_e) ? idx_q : nxt_idx;
      end
      PED_WALK: if (done) begin
        state_d = ALL_RED;
        idx_d   = nxt_idx;
      end
      EMERG: if (done && !emerg_req[idx_q]) begin
        state_d = ALL_RED;
        idx_d   = nxt_idx;
      end
      default: state_d = ALL_RED;
    endcase
    ped_entry   = state_d == PED_WALK && state_q != PED_WALK;
    green_entry = state_d == GREEN && state_q != GREEN;
    ped_d       = ped_entry ? '0 : ped_q | ped_req;
    walk_d      = ped_entry ? ped_q | ped_req : walk_q;
    long_d      = green_entry ? dens[idx_d] >= DENS_HI : long_q;
  end
  always_comb begin
    onehot       = N_APPROACH'(1) << idx_q;
    light_green  = (state_q == GREEN || state_q == EMERG) ? onehot : '0;
    light_yellow = state_q == YELLOW ? onehot : '0;
    light_red    = ~(light_green | light_yellow);
    ped_walk     = state_q == PED_WALK ? walk_q : '0;
    emerg_active = state_q == EMERG;
    active_idx   = idx_q;
  end
endmodule
